// File: rtl/w21_col_mac_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : w21_pkg
//  Purpose  : Shared constants, sequencer state type and result saturation
//             helper for the W21 column MAC sequencer.
//  Contents : N_ROWS, DATA_W, ACC_W, FRAC_BITS, ADDR_W, seq_state_t,
//             sat_shift()
//  Revision : 1.0  initial release
// ============================================================================
package w21_pkg;

    localparam int N_ROWS    = 300;
    localparam int DATA_W    = 21;
    localparam int ACC_W     = 51;
    localparam int FRAC_BITS = 10;
    localparam int ADDR_W    = 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

    // Largest / smallest representable DATA_W value, held at accumulator width
    // so the shifted accumulator can be compared directly.
    localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    localparam logic [DATA_W-1:0] RES_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] RES_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Arithmetic right shift by frac, then clamp into the signed DATA_W range.
    function automatic logic [DATA_W-1:0] sat_shift(
        input logic signed [ACC_W-1:0] acc,
        input int unsigned             frac
    );
        logic signed [ACC_W-1:0] v;
        v = acc >>> frac;
        if (v > SAT_HI) begin
            sat_shift = RES_MAX;
        end else if (v < SAT_LO) begin
            sat_shift = RES_MIN;
        end else begin
            sat_shift = v[DATA_W-1:0];
        end
    endfunction

endpackage : w21_pkg
`default_nettype wire

// File: rtl/w21_col_mac_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : w21_col_mac_seq_if
//  Purpose  : Bundle of control, memory-address and result handshake signals
//             between the layer controller / activation stage and the
//             W21 column MAC sequencer.
//  Ports    : start, abort       - pass control from the layer controller
//             adrs_clm           - column address to ROM and activation store
//             w_data, x_data     - combinational weight / activation for it
//             busy               - sequencer not idle
//             res_valid/ready    - result handshake, res_data the result
//  Modports : master (controller / consumer side), slave (sequencer side)
//  Revision : 1.0  initial release
// ============================================================================
interface w21_col_mac_seq_if
    import w21_pkg::*;
#(
    parameter int DATA_W = w21_pkg::DATA_W,
    parameter int ADDR_W = w21_pkg::ADDR_W
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] adrs_clm;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] x_data;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    modport master (
        output start, abort, w_data, x_data, res_ready,
        input  adrs_clm, busy, res_valid, res_data
    );

    modport slave (
        input  start, abort, w_data, x_data, res_ready,
        output adrs_clm, busy, res_valid, res_data
    );

endinterface : w21_col_mac_seq_if
`default_nettype wire

// File: rtl/w21_col_mac_seq_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : w21_mac_pipe
//  Purpose  : Two-stage signed multiply-accumulate datapath with a saturated,
//             registered result.
//             Stage 1 registers w*x with a valid bit, stage 2 adds the
//             sign-extended product into the accumulator.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             i_clear           - drop pipeline valid and zero accumulator
//             i_issue           - current w/x pair is part of the pass
//             i_capture         - load saturated result register
//             i_w_data, i_x_data- signed operands
//             o_res_data        - saturated result register
//  Revision : 1.0  initial release
// ============================================================================
module w21_mac_pipe
    import w21_pkg::*;
#(
    parameter int DATA_W    = w21_pkg::DATA_W,
    parameter int ACC_W     = w21_pkg::ACC_W,
    parameter int FRAC_BITS = w21_pkg::FRAC_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_issue,
    input  logic              i_capture,
    input  logic [DATA_W-1:0] i_w_data,
    input  logic [DATA_W-1:0] i_x_data,
    output logic [DATA_W-1:0] o_res_data
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [DATA_W-1:0] w_w;
    logic signed [DATA_W-1:0] w_x;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic [DATA_W-1:0]        w_sat;

    logic signed [PROD_W-1:0] r_prod;
    logic                     r_prod_vld;
    logic signed [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0]        r_res;

    assign w_w        = $signed(i_w_data);
    assign w_x        = $signed(i_x_data);
    assign w_prod     = w_w * w_x;
    assign w_prod_ext = {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};

    // Stage 1 product register and stage 2 accumulator. ACC_W leaves nine
    // guard bits above the product, enough for 512 full-scale terms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else if (i_clear) begin
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_prod     <= w_prod;
            r_prod_vld <= i_issue;
            if (r_prod_vld) begin
                r_acc <= r_acc + w_prod_ext;
            end
        end
    end

    // Default widths use the shared helper; other widths get the same
    // shift-and-clamp built at the local widths.
    generate
        if (DATA_W == w21_pkg::DATA_W && ACC_W == w21_pkg::ACC_W) begin : g_sat_pkg
            assign w_sat = sat_shift(r_acc, FRAC_BITS);
        end else begin : g_sat_generic
            localparam logic signed [ACC_W-1:0] L_HI =
                {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
            localparam logic signed [ACC_W-1:0] L_LO = ~L_HI;
            logic signed [ACC_W-1:0] w_shr;
            assign w_shr = r_acc >>> FRAC_BITS;
            assign w_sat = (w_shr > L_HI) ? {1'b0, {(DATA_W-1){1'b1}}} :
                           (w_shr < L_LO) ? {1'b1, {(DATA_W-1){1'b0}}} :
                                            w_shr[DATA_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= '0;
        end else if (i_capture) begin
            r_res <= w_sat;
        end
    end

    assign o_res_data = r_res;

endmodule : w21_mac_pipe
`default_nettype wire

// File: rtl/w21_col_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : w21_col_mac_seq
//  Purpose  : Sequencer for one W21 weight column. On start, walks the column
//             address 0..N_ROWS-1, multiply-accumulates weight x activation,
//             then offers one saturated DATA_W result over valid/ready.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-high reset
//             bus  - w21_col_mac_seq_if.slave (start/abort, adrs_clm,
//                    w_data/x_data, busy, res_valid/res_ready/res_data)
//  Revision : 1.0  initial release
// ============================================================================
module w21_col_mac_seq
    import w21_pkg::*;
#(
    parameter int N_ROWS    = w21_pkg::N_ROWS,
    parameter int DATA_W    = w21_pkg::DATA_W,
    parameter int ACC_W     = w21_pkg::ACC_W,
    parameter int FRAC_BITS = w21_pkg::FRAC_BITS
) (
    input  logic             clk,
    input  logic             rst,
    w21_col_mac_seq_if.slave bus
);

    localparam int                ADDR_W = w21_pkg::ADDR_W;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(N_ROWS - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_drain;

    logic              w_clear;
    logic              w_issue;
    logic              w_capture;
    logic [DATA_W-1:0] w_res_data;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. abort wins over start in IDLE and over res_ready
    // in DONE.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_drain) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.abort || bus.res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        bus.adrs_clm  = r_cnt;
        bus.busy      = (r_state != S_IDLE);
        bus.res_valid = (r_state == S_DONE);
        bus.res_data  = w_res_data;
        w_issue       = (r_state == S_RUN);
        w_clear       = ((r_state == S_IDLE) && bus.start && !bus.abort) ||
                        ((r_state != S_IDLE) && bus.abort);
        // Second DRAIN cycle: the last product was added one edge earlier.
        w_capture     = (r_state == S_DRAIN) && r_drain && !bus.abort;
    end

    // Address counter: zero whenever heading back to IDLE, so IDLE always
    // presents address 0; holds at the last address through DRAIN/DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_state_nxt == S_IDLE) begin
            r_cnt <= '0;
        end else if ((r_state == S_RUN) && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + ADDR_W'(1);
        end
    end

    // Marks the second DRAIN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain <= 1'b0;
        end else begin
            r_drain <= (r_state == S_DRAIN) && (w_state_nxt == S_DRAIN);
        end
    end

    w21_mac_pipe #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_mac_pipe (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_issue    (w_issue),
        .i_capture  (w_capture),
        .i_w_data   (bus.w_data),
        .i_x_data   (bus.x_data),
        .o_res_data (w_res_data)
    );

endmodule : w21_col_mac_seq
`default_nettype wire

// File: tb/tb_w21_col_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_w21_col_mac_seq
//  Purpose  : Directed bench for w21_col_mac_seq. Two instances share clock
//             and reset: FRAC_BITS=0 and FRAC_BITS=10. A table of operand
//             patterns with hand-computed results is swept, followed by
//             backpressure, abort, reset and back-to-back sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_w21_col_mac_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_v = 1'b0;
    logic abort_v = 1'b0;
    logic ready_v = 1'b1;
    int   sel     = 0;
    int   mode    = 0;

    int n_vec = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int cyc_abs = 0;

    w21_col_mac_seq_if #(.DATA_W(21), .ADDR_W(9)) bus0 ();
    w21_col_mac_seq_if #(.DATA_W(21), .ADDR_W(9)) bus10 ();

    // Operand model: weight/activation returned for an address.
    function automatic logic [20:0] model_w(input int m, input logic [8:0] a);
        int v;
        case (m)
            1:       v = a[0] ? -1000 : 2000;
            2:       v = a[0] ? 1000 : -2000;
            3:       v = 32'h000F_FFFF;
            4:       v = -1048576;
            5:       v = -1;
            default: v = 1;
        endcase
        return 21'(v);
    endfunction

    function automatic logic [20:0] model_x(input int m, input logic [8:0] a);
        case (m)
            1, 2:    return {12'd0, a};
            3, 4:    return 21'h0F_FFFF;
            default: return 21'd1;
        endcase
    endfunction

    assign bus0.start      = start_v && (sel == 0);
    assign bus10.start     = start_v && (sel == 1);
    assign bus0.abort      = abort_v;
    assign bus10.abort     = abort_v;
    assign bus0.res_ready  = ready_v;
    assign bus10.res_ready = ready_v;
    assign bus0.w_data     = model_w(mode, bus0.adrs_clm);
    assign bus0.x_data     = model_x(mode, bus0.adrs_clm);
    assign bus10.w_data    = model_w(mode, bus10.adrs_clm);
    assign bus10.x_data    = model_x(mode, bus10.adrs_clm);

    w21_col_mac_seq #(.N_ROWS(300), .DATA_W(21), .ACC_W(51), .FRAC_BITS(0)) u_dut_f0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    w21_col_mac_seq #(.N_ROWS(300), .DATA_W(21), .ACC_W(51), .FRAC_BITS(10)) u_dut_f10 (
        .clk (clk),
        .rst (rst),
        .bus (bus10)
    );

    always @(posedge clk) begin
        cyc_abs <= cyc_abs + 1;
        if (bus0.res_valid && bus0.res_ready && !abort_v) hs_cnt <= hs_cnt + 1;
    end

    function automatic logic get_valid();
        return (sel == 1) ? bus10.res_valid : bus0.res_valid;
    endfunction
    function automatic logic get_busy();
        return (sel == 1) ? bus10.busy : bus0.busy;
    endfunction
    function automatic logic [8:0] get_adrs();
        return (sel == 1) ? bus10.adrs_clm : bus0.adrs_clm;
    endfunction
    function automatic logic [20:0] get_data();
        return (sel == 1) ? bus10.res_data : bus0.res_data;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One pass: start in cycle 0, address order checked through cycle 300,
    // returns at the falling edge of the cycle where res_valid is first seen.
    task automatic run_pass(input logic [20:0] exp, input string tag);
        int   cyc;
        int   gaps;
        logic seen;
        logic busy1;
        gaps  = 0;
        seen  = 1'b0;
        busy1 = 1'b0;
        @(posedge clk); #1 start_v = 1'b1;
        @(posedge clk); #1 start_v = 1'b0;
        cyc = 1;
        while (cyc < 400) begin
            @(negedge clk);
            if (cyc == 1) busy1 = get_busy();
            if (get_valid()) begin
                seen = 1'b1;
                break;
            end
            if (cyc <= 300 && get_adrs() != 9'(cyc - 1)) gaps++;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_busy_rise"}, int'(busy1), 1);
        check({tag, "_valid_cycle"}, seen ? cyc : -1, 303);
        check({tag, "_addr_gaps"}, gaps, 0);
        check({tag, "_data"}, int'(get_data()), int'(exp));
    endtask

    typedef struct {
        string       name;
        int          mode;
        int          sel;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bad;
        int          vseen;
        int          n;
        int          hs0;
        int          t1;
        logic [20:0] d0;

        vecs[0] = '{"ones_f0",      0, 0, 21'd300};
        vecs[1] = '{"ones_f10",     0, 1, 21'd0};
        vecs[2] = '{"alt_pos_f10",  1, 1, 21'd21679};
        vecs[3] = '{"alt_neg_f10",  2, 1, 21'h1F_AB50};
        vecs[4] = '{"sat_pos_f10",  3, 1, 21'h0F_FFFF};
        vecs[5] = '{"sat_neg_f10",  4, 1, 21'h10_0000};
        vecs[6] = '{"neg_ones_f0",  5, 0, 21'h1F_FED4};
        vecs[7] = '{"sat_pos_f0",   3, 0, 21'h0F_FFFF};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_adrs",  int'(bus0.adrs_clm), 0);
        check("rst_busy",  int'(bus0.busy), 0);
        check("rst_valid", int'(bus0.res_valid), 0);
        check("rst_data",  int'(bus0.res_data), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Table sweep, res_ready held high
        for (int i = 0; i < 8; i++) begin
            sel     = vecs[i].sel;
            mode    = vecs[i].mode;
            ready_v = 1'b1;
            run_pass(vecs[i].exp, vecs[i].name);
            @(negedge clk);
            check({vecs[i].name, "_valid_1cyc"}, int'(get_valid()), 0);
            check({vecs[i].name, "_busy_fall"},  int'(get_busy()), 0);
        end

        // Backpressure: result held 20 cycles, start in DONE ignored
        sel = 0; mode = 0; ready_v = 1'b0;
        hs0 = hs_cnt;
        run_pass(21'd300, "bp");
        d0  = get_data();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1 start_v = (i == 10);
            @(negedge clk);
            if (!get_valid() || get_data() !== d0) bad++;
        end
        start_v = 1'b0;
        check("bp_hold", bad, 0);
        ready_v = 1'b1;
        vseen = 0;
        repeat (320) begin
            @(negedge clk);
            if (get_valid()) vseen++;
        end
        check("bp_no_second_pass", vseen, 0);
        check("bp_pass_count", hs_cnt - hs0, 1);

        // Abort at address 150
        hs0 = hs_cnt;
        @(posedge clk); #1 start_v = 1'b1;
        @(posedge clk); #1 start_v = 1'b0;
        n = 0;
        @(negedge clk);
        while (get_adrs() != 9'd150 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_150", int'(n < 400), 1);
        abort_v = 1'b1;
        @(posedge clk); #1 abort_v = 1'b0;
        vseen = 0;
        repeat (320) begin
            @(negedge clk);
            if (get_valid()) vseen++;
        end
        check("abort_no_valid", vseen, 0);
        check("abort_idle", int'(get_busy()), 0);
        check("abort_no_hs", hs_cnt - hs0, 0);
        run_pass(21'd300, "after_abort");
        @(negedge clk);

        // abort together with start in IDLE stays idle
        start_v = 1'b1; abort_v = 1'b1;
        @(posedge clk); #1 start_v = 1'b0; abort_v = 1'b0;
        @(negedge clk);
        check("abort_start_idle", int'(get_busy()), 0);

        // Back-to-back: restart in the first IDLE cycle after the handshake
        run_pass(21'd300, "b2b_first");
        t1 = cyc_abs;
        @(posedge clk); #1 start_v = 1'b1;
        @(posedge clk); #1 start_v = 1'b0;
        n = 0;
        @(negedge clk);
        while (!get_valid() && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("b2b_spacing", cyc_abs - t1, 304);
        check("b2b_data", int'(get_data()), 300);
        @(negedge clk);

        // Reset mid-RUN clears outputs immediately
        @(posedge clk); #1 start_v = 1'b1;
        @(posedge clk); #1 start_v = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        check("mid_run_busy", int'(bus0.busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_adrs",  int'(bus0.adrs_clm), 0);
        check("mid_rst_busy",  int'(bus0.busy), 0);
        check("mid_rst_valid", int'(bus0.res_valid), 0);
        check("mid_rst_data",  int'(bus0.res_data), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_w21_col_mac_seq
`default_nettype wire
